// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StWait
    } lcd_state_e;

    // Control register field positions
    localparam int LCD_ON_BIT  = 31;
    localparam int LCD_STB_BIT = 10;
    localparam int LCD_RS_BIT  = 9;
    localparam int LCD_RW_BIT  = 8;

    // Status word field positions
    localparam int STAT_BUSY_BIT = 31;
    localparam int STAT_DROP_BIT = 30;
    localparam int STAT_RDV_BIT  = 8;

    // Commands that need the long execution wait
    localparam logic [7:0] LCD_OP_CLEAR = 8'h01;
    localparam logic [7:0] LCD_OP_HOME  = 8'h02;

    // Clear/home are instruction writes (RS=0, RW=0) with the matching opcode.
    function automatic logic is_long_cmd(input logic rs, input logic rw, input logic [7:0] data);
        return !rs && !rw && ((data == LCD_OP_CLEAR) || (data == LCD_OP_HOME));
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that stops at zero and flags it.
module lcd_cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Turns a software strobe in the LCD control register into a timed HD44780 bus cycle
// and exposes a pollable status word.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned EXEC_CYC  = 2000,
    parameter int unsigned CLEAR_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    input  logic [7:0]  i_lcd_data,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_data_oe,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic [31:0] o_status
);

    localparam int unsigned CNT_W = $clog2(CLEAR_CYC + 1);

    // Counter preload values: a state of N cycles loads N-1 on entry.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

    lcd_state_e       r_state;
    logic             r_stb_prev;
    logic             r_drop;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;
    logic             r_lat_rs;
    logic             r_lat_rw;
    logic [7:0]       r_lat_data;
    logic             r_lcd_en;
    logic             r_lcd_rs;
    logic             r_lcd_rw;
    logic [7:0]       r_lcd_data;
    logic             r_lcd_oe;
    logic             r_lcd_on;
    logic             r_busy;

    logic             w_on;
    logic             w_stb_edge;
    logic             w_accept;
    logic             w_abort;
    logic             w_advance;
    logic             w_zero;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_wait_ld;
    logic             w_unused_bits;

    assign w_on       = i_lcd_reg[LCD_ON_BIT];
    assign w_stb_edge = i_lcd_reg[LCD_STB_BIT] & ~r_stb_prev;
    assign w_accept   = (r_state == StIdle) && w_on && w_stb_edge;
    // Losing ON mid-transaction abandons the bus cycle.
    assign w_abort    = (r_state != StIdle) && !w_on;
    assign w_advance  = (r_state != StIdle) && w_zero && !w_abort;

    assign w_unused_bits = ^i_lcd_reg[30:11];

    // Select the counter preload for whichever state is entered next.
    always_comb begin
        w_wait_ld  = is_long_cmd(r_lat_rs, r_lat_rw, r_lat_data) ? CLEAR_LD : EXEC_LD;
        w_load     = 1'b0;
        w_load_val = SETUP_LD;
        if (w_accept) begin
            w_load     = 1'b1;
            w_load_val = SETUP_LD;
        end else if (w_advance) begin
            case (r_state)
                StSetup: begin
                    w_load     = 1'b1;
                    w_load_val = PULSE_LD;
                end
                StPulse: begin
                    w_load     = 1'b1;
                    w_load_val = HOLD_LD;
                end
                StHold: begin
                    w_load     = 1'b1;
                    w_load_val = w_wait_ld;
                end
                default: begin
                    w_load     = 1'b0;
                    w_load_val = SETUP_LD;
                end
            endcase
        end
    end

    lcd_cycle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Strobe history for edge detection and registered ON copy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stb_prev <= 1'b0;
            r_lcd_on   <= 1'b0;
        end else begin
            r_stb_prev <= i_lcd_reg[LCD_STB_BIT];
            r_lcd_on   <= w_on;
        end
    end

    // Sticky flag for strobes that arrive while a transaction is running.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drop <= 1'b0;
        end else if (w_stb_edge && w_on && (r_state != StIdle)) begin
            r_drop <= 1'b1;
        end
    end

    // Bus-cycle FSM; outputs are registered against the state being entered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_lat_rs   <= 1'b0;
            r_lat_rw   <= 1'b0;
            r_lat_data <= 8'h00;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_lcd_oe   <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_abort) begin
            r_state    <= StIdle;
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_lcd_oe   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state    <= StSetup;
                        r_lat_rs   <= i_lcd_reg[LCD_RS_BIT];
                        r_lat_rw   <= i_lcd_reg[LCD_RW_BIT];
                        r_lat_data <= i_lcd_reg[7:0];
                        r_lcd_rs   <= i_lcd_reg[LCD_RS_BIT];
                        r_lcd_rw   <= i_lcd_reg[LCD_RW_BIT];
                        r_lcd_data <= i_lcd_reg[7:0];
                        r_lcd_oe   <= ~i_lcd_reg[LCD_RW_BIT];
                        r_busy     <= 1'b1;
                        r_rd_valid <= 1'b0;
                    end
                end
                StSetup: begin
                    if (w_zero) begin
                        r_state  <= StPulse;
                        r_lcd_en <= 1'b1;
                    end
                end
                StPulse: begin
                    if (w_zero) begin
                        r_state  <= StHold;
                        r_lcd_en <= 1'b0;
                        // Read data is sampled while EN is still high.
                        if (r_lat_rw) begin
                            r_rd_data  <= i_lcd_data;
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (w_zero) begin
                        r_state  <= StWait;
                        r_lcd_oe <= 1'b0;
                    end
                end
                StWait: begin
                    if (w_zero) begin
                        r_state    <= StIdle;
                        r_lcd_rs   <= 1'b0;
                        r_lcd_rw   <= 1'b0;
                        r_lcd_data <= 8'h00;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_lcd_en      = r_lcd_en;
    assign o_lcd_rs      = r_lcd_rs;
    assign o_lcd_rw      = r_lcd_rw;
    assign o_lcd_data    = r_lcd_data;
    assign o_lcd_data_oe = r_lcd_oe;
    assign o_lcd_on      = r_lcd_on;
    assign o_busy        = r_busy;
    assign o_status      = {r_busy, r_drop, 21'b0, r_rd_valid, r_rd_data};

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Consumes the 32-bit LCD control register driven by the LSU output buffer (address 0x1000_4000 region).
- Turns a software strobe into a correctly timed HD44780-style bus cycle: setup, enable pulse, hold, execution wait.
- Produces a status word that the LSU can load back, so software polls busy instead of bit-banging delays.

Parameters:
- SETUP_CYC, 2, cycles RS/RW/DATA are stable before EN rises (min 1)
- PULSE_CYC, 12, EN high width in cycles (>=230 ns at 50 MHz; min 1)
- HOLD_CYC, 2, cycles RS/RW/DATA are held after EN falls (min 1)
- EXEC_CYC, 2000, post-cycle wait for normal commands and data (40 us at 50 MHz; min 1)
- CLEAR_CYC, 82000, post-cycle wait for clear/home commands (1.64 ms at 50 MHz; must be >= EXEC_CYC)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_lcd_reg  in  32  LCD register: [31] ON, [10] STROBE, [9] RS, [8] RW, [7:0] DATA
- i_lcd_data  in  8  LCD data bus input, used for reads
- o_lcd_data  out  8  LCD data bus output value
- o_lcd_data_oe  out  1  data bus output enable; the top level builds the tristate
- o_lcd_en  out  1  LCD enable
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD read/write (1 = read)
- o_lcd_on  out  1  LCD power/backlight
- o_busy  out  1  transaction in progress
- o_status  out  32  status word: [31] busy, [30] drop, [8] rd_valid, [7:0] rd_data, all other bits 0

Behaviour:
- Reset: every output is 0; FSM is in IDLE; the strobe history register, drop flag, rd_valid and rd_data are cleared.
- o_lcd_on is a registered copy of i_lcd_reg[31], one cycle of latency.
- Trigger is a rising edge of i_lcd_reg[10] against its registered previous sample.
  - Accepted only when the FSM is in IDLE and i_lcd_reg[31] = 1.
  - On accept, RS, RW and DATA are latched. The FSM enters SETUP and o_busy = 1 from the next cycle.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
  - A single down-counter is loaded with N-1 on entry to each state; the state advances when the counter reaches 0.
  - Resulting state lengths: SETUP_CYC, PULSE_CYC, HOLD_CYC, and WAIT_N.
- WAIT_N is CLEAR_CYC when the latched RS = 0, RW = 0 and DATA is 0x01 or 0x02. Otherwise WAIT_N is EXEC_CYC.
- Counter width is $clog2(CLEAR_CYC+1).
- Bus outputs:
  - o_lcd_en = 1 only in PULSE.
  - o_lcd_rs, o_lcd_rw and o_lcd_data come from the latched values in SETUP, PULSE, HOLD and WAIT.
  - o_lcd_rs, o_lcd_rw and o_lcd_data are 0 in IDLE.
  - o_lcd_data_oe = ~latched RW in SETUP, PULSE and HOLD; 0 otherwise.
- Read (RW = 1):
  - i_lcd_data is captured into rd_data on the last PULSE cycle.
  - rd_valid is set at that point.
  - rd_valid is cleared when the next transaction is accepted.
- Total busy time = SETUP_CYC + PULSE_CYC + HOLD_CYC + WAIT_N cycles. o_busy drops when the FSM returns to IDLE.
- Strobe edge while not in IDLE: the edge is ignored and drop is set. Drop is sticky until reset.
- Strobe edge while i_lcd_reg[31] = 0: ignored, and drop is not set.
- ON deasserted mid-transaction:
  - The FSM returns to IDLE on the next cycle, with o_lcd_en forced to 0 that cycle.
  - rd_valid is unchanged.
- Strobe held high does not retrigger; software must clear it first.
- Reset asserted mid-transaction: all state and outputs clear immediately, since the reset is asynchronous.
- o_status is registered from internal state and is valid in the same cycle as o_busy.

Decomposition:
- lcd_pkg holds:
  - state enum lcd_state_e (IDLE, SETUP, PULSE, HOLD, WAIT)
  - field bit positions LCD_ON_BIT = 31, LCD_STB_BIT = 10, LCD_RS_BIT = 9, LCD_RW_BIT = 8
  - status bit positions
  - clear/home opcodes 8'h01 and 8'h02
- One sub-module, lcd_cycle_timer: a loadable down-counter with a zero flag, parameterised by width.

Test Plan:
Simulation parameters: SETUP_CYC = 2, PULSE_CYC = 4, HOLD_CYC = 2, EXEC_CYC = 10, CLEAR_CYC = 30.
- Data write: ON = 1, then i_lcd_reg = 0x8000_0641 (STROBE, RS = 1, DATA = 0x41). Required: o_busy goes high 1 cycle later; EN is high for exactly 4 cycles starting 2 cycles after busy rises; RS = 1, DATA = 0x41, OE = 1 throughout SETUP/PULSE/HOLD; busy lasts 18 cycles.
- Clear command: i_lcd_reg = 0x8000_0401. Required: busy lasts 38 cycles (2 + 4 + 2 + 30); EN pulse width is 4 cycles.
- Read: i_lcd_reg = 0x8000_0500 with i_lcd_data = 0x80 during PULSE. Required: OE = 0; after PULSE, o_status = 0x8000_0180 while busy, then 0x0000_0180 once busy drops.
- Strobe while busy: toggle STROBE low then high during WAIT. Required: no second EN pulse; o_status[30] = 1 and stays 1 after later transactions.
- ON drop and reset abort: clear bit 31 during PULSE. Required: EN = 0 next cycle and FSM back in IDLE. In a separate run, assert i_reset during HOLD. Required: all outputs 0 immediately.
